uart_fifo_param: RTL and testbench

- Parametrised successor to the 8-bit/16-deep UART FIFO, for both the RX and TX paths of the UART.
- Width and depth are configurable. Adds an occupancy output, a selectable threshold direction, a synchronous flush, and sticky error flags with an explicit clear.
- Sits between the UART shift-register logic and the host bus. Instantiated once per direction.

---
 rtl/uart_fifo_param.sv | 94 +++++++++
 tb/tb_uart_fifo_param.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// Parametrised UART FIFO: FWFT circular buffer with occupancy,
// threshold trigger, flush and sticky error flags.
module uart_fifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [DATA_W-1:0] din,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [LVL_W-1:0]  threshold,
    input  logic              trig_mode,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic              overrun,
    output logic              underrun,
    output logic              thr_trigger
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic              push_ok;
    logic              pop_ok;
    logic              ovr_set;
    logic              und_set;
    logic              thr_nxt;

    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    // At full a concurrent pop frees the slot, so the push is taken
    always_comb begin
        pop_ok    = en & pop_in & ~empty;
        push_ok   = en & push_in & (~full | pop_ok);
        ovr_set   = en & push_in & full & ~pop_in & ~flush;
        und_set   = en & pop_in & empty & ~flush;
        level_nxt = level_q;
        if (flush)
            level_nxt = '0;
        else if (push_ok && !pop_ok)
            level_nxt = level_q + LVL_W'(1);
        else if (pop_ok && !push_ok)
            level_nxt = level_q - LVL_W'(1);
        thr_nxt = 1'b0;
        if (threshold != '0)
            thr_nxt = trig_mode ? (level_nxt <= threshold)
                                : (level_nxt >= threshold);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            thr_trigger <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q     <= level_nxt;
            thr_trigger <= thr_nxt;
            overrun     <= ovr_set | (overrun & ~clr_err);
            underrun    <= und_set | (underrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_fifo_param.sv
// Scoreboard bench for uart_fifo_param (DATA_W=8, DEPTH=16).
module tb_uart_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       push_in;
    logic       pop_in;
    logic [7:0] din;
    logic       flush;
    logic       clr_err;
    logic [4:0] threshold;
    logic       trig_mode;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;
    logic       underrun;
    logic       thr_trigger;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];

    uart_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .push_in(push_in),
        .pop_in(pop_in), .din(din), .flush(flush), .clr_err(clr_err),
        .threshold(threshold), .trig_mode(trig_mode), .dout(dout),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .underrun(underrun), .thr_trigger(thr_trigger)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle and updates the reference queue
    task automatic cyc(input bit p, input bit r, input logic [7:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = r && en && (q.size() > 0);
        push_ok = p && en && ((q.size() < 16) || pop_ok);
        push_in = p;
        pop_in  = r;
        din     = d;
        if (flush) begin
            q.delete();
        end else begin
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        tick();
        push_in = 1'b0;
        pop_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; push_in = 1'b0; pop_in = 1'b0;
        din = '0; flush = 1'b0; clr_err = 1'b0;
        threshold = 5'd10; trig_mode = 1'b0;
        #3;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
            dout !== 8'd0 || overrun !== 1'b0 || underrun !== 1'b0 ||
            thr_trigger !== 1'b0) begin
            failures++;
            $display("FAIL reset lvl=%0d e=%b f=%b d=%h o=%b u=%b t=%b exp 0/1/0/00/0/0/0",
                     level, empty, full, dout, overrun, underrun, thr_trigger);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || dout !== 8'd0) begin
            failures++;
            $display("FAIL post_reset lvl=%0d e=%b d=%h exp 0/1/00", level, empty, dout);
        end
    endtask

    task automatic test_fill();
        en = 1'b1; trig_mode = 1'b0; threshold = 5'd10;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (level !== 5'(i) || thr_trigger !== (i >= 10) ||
                full !== (i == 16) || empty !== 1'b0) begin
                failures++;
                $display("FAIL fill[%0d] lvl=%0d thr=%b full=%b e=%b exp lvl=%0d thr=%b full=%b",
                         i, level, thr_trigger, full, empty, i, i >= 10, i == 16);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL fill_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_overrun_drain();
        logic [7:0] exp;
        cyc(1'b1, 1'b0, 8'hA5);
        checks++;
        if (overrun !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL overrun o=%b lvl=%0d f=%b exp 1/16/1", overrun, level, full);
        end
        for (int i = 0; i < 16; i++) begin
            exp = q[0];
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL drain_data[%0d] got=%h exp=%h", i, dout, exp);
            end
            cyc(1'b0, 1'b1, 8'h00);
            checks++;
            if (level !== 5'(15 - i) || thr_trigger !== ((15 - i) >= 10)) begin
                failures++;
                $display("FAIL drain_lvl[%0d] lvl=%0d thr=%b exp lvl=%0d thr=%b",
                         i, level, thr_trigger, 15 - i, (15 - i) >= 10);
            end
        end
        checks++;
        if (empty !== 1'b1 || dout !== 8'd0 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL drain_end e=%b d=%h u=%b exp 1/00/0", empty, dout, underrun);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL clr_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_underrun();
        cyc(1'b0, 1'b1, 8'h00);
        checks++;
        if (underrun !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL pop_empty u=%b lvl=%0d exp 1/0", underrun, level);
        end
        cyc(1'b1, 1'b1, 8'h3C);
        checks++;
        if (underrun !== 1'b1 || level !== 5'd1 || dout !== 8'h3C || empty !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_empty u=%b lvl=%0d d=%h e=%b exp 1/1/3c/0",
                     underrun, level, dout, empty);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL clr_underrun got=%b exp=0", underrun);
        end
        cyc(1'b0, 1'b1, 8'h00);
        clr_err = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        clr_err = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_set got=%b exp=1", underrun);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int r = 0; r < 5; r++) begin
            while (q.size() < 8) cyc(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (level !== 5'd8) begin
                failures++;
                $display("FAIL wrap_fill[%0d] lvl=%0d exp=8", r, level);
            end
            for (int k = 0; k < 4; k++) begin
                exp = q[0];
                checks++;
                if (dout !== exp) begin
                    failures++;
                    $display("FAIL wrap_data[%0d.%0d] got=%h exp=%h", r, k, dout, exp);
                end
                cyc(1'b0, 1'b1, 8'h00);
            end
        end
        while (q.size() < 16) cyc(1'b1, 1'b0, 8'($urandom));
        for (int k = 0; k < 5; k++) begin
            exp = q[0];
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL full_pp_data[%0d] got=%h exp=%h", k, dout, exp);
            end
            cyc(1'b1, 1'b1, 8'($urandom));
            checks++;
            if (level !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
                failures++;
                $display("FAIL full_pp[%0d] lvl=%0d o=%b f=%b exp 16/0/1",
                         k, level, overrun, full);
            end
        end
        while (q.size() > 0) begin
            exp = q[0];
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL wrap_drain got=%h exp=%h left=%0d", dout, exp, q.size());
            end
            cyc(1'b0, 1'b1, 8'h00);
        end
        checks++;
        if (empty !== 1'b1 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end e=%b u=%b exp 1/0", empty, underrun);
        end
    endtask

    task automatic test_tx_trigger();
        int lv;
        trig_mode = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            threshold = (pass == 0) ? 5'd4 : 5'd0;
            for (int i = 1; i <= 6; i++) begin
                cyc(1'b1, 1'b0, 8'(i));
                checks++;
                if (thr_trigger !== (pass == 0 && i <= 4)) begin
                    failures++;
                    $display("FAIL tx_up[%0d.%0d] got=%b exp=%b",
                             pass, i, thr_trigger, pass == 0 && i <= 4);
                end
            end
            for (int i = 5; i >= 0; i--) begin
                cyc(1'b0, 1'b1, 8'h00);
                lv = q.size();
                checks++;
                if (level !== 5'(lv) || thr_trigger !== (pass == 0 && lv <= 4)) begin
                    failures++;
                    $display("FAIL tx_dn[%0d.%0d] lvl=%0d thr=%b exp lvl=%0d thr=%b",
                             pass, i, level, thr_trigger, lv, pass == 0 && lv <= 4);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        trig_mode = 1'b0; threshold = 5'd10;
        while (q.size() < 16) cyc(1'b1, 1'b0, 8'($urandom));
        cyc(1'b1, 1'b0, 8'hEE);
        while (q.size() > 7) cyc(1'b0, 1'b1, 8'h00);
        checks++;
        if (level !== 5'd7 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL pre_flush lvl=%0d o=%b exp 7/1", level, overrun);
        end
        flush = 1'b1;
        cyc(1'b1, 1'b0, 8'h77);
        flush = 1'b0;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || dout !== 8'd0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL flush lvl=%0d e=%b d=%h o=%b exp 0/1/00/1",
                     level, empty, dout, overrun);
        end
        trig_mode = 1'b1; threshold = 5'd8;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        checks++;
        if (level !== 5'd5 || dout !== 8'h50 || thr_trigger !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst lvl=%0d d=%h thr=%b exp 5/50/1", level, dout, thr_trigger);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'd0 ||
            overrun !== 1'b0 || underrun !== 1'b0 || thr_trigger !== 1'b0) begin
            failures++;
            $display("FAIL async_rst lvl=%0d e=%b f=%b d=%h o=%b u=%b t=%b exp 0/1/0/00/0/0/0",
                     level, empty, full, dout, overrun, underrun, thr_trigger);
        end
        q.delete();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overrun_drain();
        test_underrun();
        test_wrap();
        test_tx_trigger();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
